// File: rtl/matvec_pkg.sv
// Shared types and constants for the sequential matrix-vector MAC block.
package matvec_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int EXC_W = 5;
  localparam int RM_W  = 3;

  localparam logic [RM_W-1:0] RM_RNE = 3'd0;
  localparam logic [RM_W-1:0] RM_RTZ = 3'd1;
  localparam logic [RM_W-1:0] RM_RDN = 3'd2;
  localparam logic [RM_W-1:0] RM_RUP = 3'd3;
  localparam logic [RM_W-1:0] RM_RMM = 3'd4;

  // Flag order {invalid, div-by-zero, overflow, underflow, inexact}
  localparam logic [EXC_W-1:0] FL_NV = 5'b10000;
  localparam logic [EXC_W-1:0] FL_OF = 5'b00100;
  localparam logic [EXC_W-1:0] FL_UF = 5'b00010;
  localparam logic [EXC_W-1:0] FL_NX = 5'b00001;

  function automatic int word_w(input int exp_width, input int mant_width);
    return exp_width + mant_width;
  endfunction

endpackage

// File: rtl/fp_mac_unit.sv
// Combinational multiply-then-add step: sum = first ? a*b : acc + a*b, each rounded.
// Subnormal operands are treated as zero and underflowing results flush to signed zero.
module fp_mac_unit import matvec_pkg::*; #(
  parameter int exp_width  = 8,
  parameter int mant_width = 24,
  localparam int W = word_w(exp_width, mant_width)
) (
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [W-1:0]     acc,
  input  logic             first,
  input  logic [RM_W-1:0]  round_mode,
  output logic [W-1:0]     sum,
  output logic [EXC_W-1:0] exc
);

  localparam int EW   = exp_width;
  localparam int MW   = mant_width;
  localparam int F    = MW - 1;
  localparam int EMAX = (1 << EW) - 1;
  localparam int BIAS = (1 << (EW - 1)) - 1;
  localparam logic [EXC_W-1:0] NOFL = '0;
  localparam logic [W-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(F-1){1'b0}}};

  typedef logic signed [EW+1:0] exp_t;

  // sig = {hidden, fraction, guard}; st = OR of all lower bits
  function automatic logic [EXC_W+W-1:0] round_pack(input logic s, input exp_t e,
      input logic [MW:0] sig, input logic st, input logic [RM_W-1:0] rm);
    logic [MW:0] m;
    logic inc, nx;
    exp_t er;
    nx = sig[0] | st;
    case (rm)
      RM_RNE:  inc = sig[0] & (st | sig[1]);
      RM_RDN:  inc = s & nx;
      RM_RUP:  inc = !s & nx;
      RM_RMM:  inc = sig[0];
      default: inc = 1'b0;
    endcase
    m  = {1'b0, sig[MW:1]} + {{MW{1'b0}}, inc};
    er = e;
    if (m[MW]) begin
      m  = m >> 1;
      er = er + 1;
    end
    if (er >= exp_t'(EMAX)) begin
      if (rm == RM_RNE || rm == RM_RMM || (rm == RM_RUP && !s) || (rm == RM_RDN && s))
        return {FL_OF | FL_NX, s, {EW{1'b1}}, {F{1'b0}}};
      return {FL_OF | FL_NX, s, {(EW-1){1'b1}}, 1'b0, {F{1'b1}}};
    end
    if (er <= exp_t'(0)) return {FL_UF | FL_NX, s, {(W-1){1'b0}}};
    return {(nx ? FL_NX : NOFL), s, er[EW-1:0], m[F-1:0]};
  endfunction

  function automatic logic [EXC_W+W-1:0] fp_mul(input logic [W-1:0] x, input logic [W-1:0] y,
      input logic [RM_W-1:0] rm);
    logic [EW-1:0] ex, ey;
    logic [F-1:0] fx, fy;
    logic s, zx, zy, ix, iy, nx, ny, bad;
    logic [2*MW-1:0] p;
    exp_t e;
    ex = x[W-2 -: EW];  fx = x[F-1:0];
    ey = y[W-2 -: EW];  fy = y[F-1:0];
    s  = x[W-1] ^ y[W-1];
    zx = (ex == '0);  ix = (&ex) && (fx == '0);  nx = (&ex) && (fx != '0);
    zy = (ey == '0);  iy = (&ey) && (fy == '0);  ny = (&ey) && (fy != '0);
    bad = (ix & zy) | (zx & iy);
    if (nx | ny | bad)
      return {(bad | (nx & !fx[F-1]) | (ny & !fy[F-1])) ? FL_NV : NOFL, QNAN};
    if (ix | iy) return {NOFL, s, {EW{1'b1}}, {F{1'b0}}};
    if (zx | zy) return {NOFL, s, {(W-1){1'b0}}};
    p = (2*MW)'({1'b1, fx}) * (2*MW)'({1'b1, fy});
    e = exp_t'({2'b00, ex}) + exp_t'({2'b00, ey}) - exp_t'(BIAS);
    if (p[2*MW-1]) e = e + 1;
    else           p = p << 1;
    return round_pack(s, e, p[2*MW-1 -: MW+1], |p[MW-2:0], rm);
  endfunction

  function automatic logic [EXC_W+W-1:0] fp_add(input logic [W-1:0] x, input logic [W-1:0] y,
      input logic op, input logic [RM_W-1:0] rm);
    logic [EW-1:0] ex, ey, ea, eb, d;
    logic [F-1:0] fx, fy, fa, fb;
    logic sx, sy, sa, sb, zx, zy, ix, iy, nx, ny, bad;
    logic [2*MW+5:0] wide;
    logic [MW+3:0] ma, mb, sm;
    exp_t e;
    sx = x[W-1];        ex = x[W-2 -: EW];  fx = x[F-1:0];
    sy = y[W-1] ^ op;   ey = y[W-2 -: EW];  fy = y[F-1:0];
    zx = (ex == '0);  ix = (&ex) && (fx == '0);  nx = (&ex) && (fx != '0);
    zy = (ey == '0);  iy = (&ey) && (fy == '0);  ny = (&ey) && (fy != '0);
    bad = ix & iy & (sx != sy);
    if (nx | ny | bad)
      return {(bad | (nx & !fx[F-1]) | (ny & !fy[F-1])) ? FL_NV : NOFL, QNAN};
    if (ix) return {NOFL, x};
    if (iy) return {NOFL, sy, {EW{1'b1}}, {F{1'b0}}};
    if (zx & zy) return {NOFL, (rm == RM_RDN) ? (sx | sy) : (sx & sy), {(W-1){1'b0}}};
    if (zx) return {NOFL, sy, ey, fy};
    if (zy) return {NOFL, x};
    if ({ey, fy} > {ex, fx}) begin
      sa = sy; ea = ey; fa = fy; sb = sx; eb = ex; fb = fx;
    end else begin
      sa = sx; ea = ex; fa = fx; sb = sy; eb = ey; fb = fy;
    end
    d    = ea - eb;
    ma   = {2'b01, fa, 3'b000};
    wide = {1'b1, fb, 3'b000, {(MW+3){1'b0}}};
    wide = wide >> ((int'(d) > MW + 3) ? MW + 3 : int'(d));
    mb   = {1'b0, wide[2*MW+5 : MW+3]};
    mb[0] = mb[0] | (|wide[MW+2:0]);
    e = exp_t'({2'b00, ea});
    if (sa == sb) begin
      sm = ma + mb;
      if (sm[MW+3]) begin
        sm = {1'b0, sm[MW+3:2], sm[1] | sm[0]};
        e  = e + 1;
      end
    end else begin
      sm = ma - mb;
      if (sm == '0) return {NOFL, rm == RM_RDN, {(W-1){1'b0}}};
      for (int i = 0; i < MW + 3; i++) begin
        if (!sm[MW+2]) begin
          sm = sm << 1;
          e  = e - 1;
        end
      end
    end
    return round_pack(sa, e, sm[MW+2:2], |sm[1:0], rm);
  endfunction

  logic [EXC_W+W-1:0] mul_r, add_r;

  assign mul_r = fp_mul(a, b, round_mode);
  assign add_r = fp_add(acc, mul_r[W-1:0], 1'b0, round_mode);
  // First term of a row loads the product directly so a -0 product keeps its sign
  assign sum   = first ? mul_r[W-1:0] : add_r[W-1:0];
  assign exc   = mul_r[W +: EXC_W] | (first ? NOFL : add_r[W +: EXC_W]);

endmodule

// File: rtl/matvec_mac_seq.sv
// Sequential FP matrix-vector multiply c = A*b on one time-multiplexed MAC.
// Define MATVEC_EXC_EN to add the sticky 'exceptions' output.
module matvec_mac_seq import matvec_pkg::*; #(
  parameter int exp_width  = 8,
  parameter int mant_width = 24,
  parameter int rows       = 2,
  parameter int cols       = 2,
  localparam int W = word_w(exp_width, mant_width)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [rows*cols*W-1:0] a_flat,
  input  logic [cols*W-1:0]      b_flat,
  input  logic [RM_W-1:0]        round_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [rows*W-1:0]      c_flat
`ifdef MATVEC_EXC_EN
  ,
  output logic [EXC_W-1:0]       exceptions
`endif
);

  localparam int RW = (rows > 1) ? $clog2(rows) : 1;
  localparam int KW = (cols > 1) ? $clog2(cols) : 1;
  localparam logic [RW-1:0] R_LAST = RW'(rows - 1);
  localparam logic [KW-1:0] K_LAST = KW'(cols - 1);

  state_t state, state_nxt;
  logic [RW-1:0] r;
  logic [KW-1:0] k;
  logic [rows*cols*W-1:0] a_q;
  logic [cols*W-1:0] b_q;
  logic [RM_W-1:0] rm_q;
  logic [W-1:0] acc, a_op, b_op, mac_sum;
  logic accept, step, row_end, last;

  assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign step      = (state == CALC);
  assign row_end   = (k == K_LAST);
  assign last      = row_end && (r == R_LAST);
  assign out_valid = (state == DONE);

  assign a_op = a_q[(int'(r) * cols + int'(k)) * W +: W];
  assign b_op = b_q[int'(k) * W +: W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = in_valid ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r <= '0;
      k <= '0;
    end else if (accept) begin
      r <= '0;
      k <= '0;
    end else if (step) begin
      if (row_end) begin
        k <= '0;
        r <= (r == R_LAST) ? '0 : r + 1'b1;
      end else begin
        k <= k + 1'b1;
      end
    end
  end

  // Job operands and running accumulator carry no reset; they are qualified by state
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q  <= a_flat;
      b_q  <= b_flat;
      rm_q <= round_mode;
    end
    if (step) acc <= mac_sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  c_flat <= '0;
    else if (step && row_end) c_flat[int'(r) * W +: W] <= mac_sum;
  end

`ifdef MATVEC_EXC_EN
  logic [EXC_W-1:0] mac_exc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         exceptions <= '0;
    else if (accept) exceptions <= '0;
    else if (step)   exceptions <= exceptions | mac_exc;
  end
`endif

  fp_mac_unit #(
    .exp_width  (exp_width),
    .mant_width (mant_width)
  ) u_mac (
    .a          (a_op),
    .b          (b_op),
    .acc        (acc),
    .first      (k == '0),
    .round_mode (rm_q),
    .sum        (mac_sum),
`ifdef MATVEC_EXC_EN
    .exc        (mac_exc)
`else
    .exc        ()
`endif
  );

endmodule

// File: tb/tb_matvec_mac_seq.sv
// Directed bench for matvec_mac_seq: 2x2, 3x4 and 1x1 instances, single precision.
module tb_matvec_mac_seq;

  localparam logic [31:0] ONE   = 32'h3F800000;
  localparam logic [31:0] TWO   = 32'h40000000;
  localparam logic [31:0] THREE = 32'h40400000;
  localparam logic [31:0] FOUR  = 32'h40800000;
  localparam logic [31:0] ZERO  = 32'h00000000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         iv22, ir22, ov22, or22;
  logic [127:0] a22;
  logic [63:0]  b22, c22;
  logic [2:0]   rm22;
  logic         iv34, ir34, ov34, or34;
  logic [383:0] a34;
  logic [127:0] b34;
  logic [95:0]  c34;
  logic [2:0]   rm34;
  logic         iv11, ir11, ov11, or11;
  logic [31:0]  a11, b11, c11;
  logic [2:0]   rm11;
`ifdef MATVEC_EXC_EN
  logic [4:0]   exc22, exc34, exc11;
`endif

  matvec_mac_seq #(.exp_width(8), .mant_width(24), .rows(2), .cols(2)) d22 (
    .clk(clk), .rst(rst), .in_valid(iv22), .in_ready(ir22), .a_flat(a22), .b_flat(b22),
    .round_mode(rm22), .out_valid(ov22), .out_ready(or22), .c_flat(c22)
`ifdef MATVEC_EXC_EN
    , .exceptions(exc22)
`endif
  );

  matvec_mac_seq #(.exp_width(8), .mant_width(24), .rows(3), .cols(4)) d34 (
    .clk(clk), .rst(rst), .in_valid(iv34), .in_ready(ir34), .a_flat(a34), .b_flat(b34),
    .round_mode(rm34), .out_valid(ov34), .out_ready(or34), .c_flat(c34)
`ifdef MATVEC_EXC_EN
    , .exceptions(exc34)
`endif
  );

  matvec_mac_seq #(.exp_width(8), .mant_width(24), .rows(1), .cols(1)) d11 (
    .clk(clk), .rst(rst), .in_valid(iv11), .in_ready(ir11), .a_flat(a11), .b_flat(b11),
    .round_mode(rm11), .out_valid(ov11), .out_ready(or11), .c_flat(c11)
`ifdef MATVEC_EXC_EN
    , .exceptions(exc11)
`endif
  );

  int nchk = 0;
  int nerr = 0;
  int n;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    iv22 = 0; or22 = 0; a22 = '0; b22 = '0; rm22 = 3'd0;
    iv34 = 0; or34 = 1; a34 = '0; b34 = '0; rm34 = 3'd0;
    iv11 = 0; or11 = 1; a11 = '0; b11 = '0; rm11 = 3'd0;
    tick;
    tick;
    chk("rst_in_ready", ir22, 1);
    chk("rst_out_valid", ov22, 0);
    chk("rst_c_flat", c22, 0);
    rst = 1'b0;
    tick;

    // Basic job with latency measurement; inputs dropped right after accept
    a22 = {FOUR, THREE, TWO, ONE}; b22 = {ONE, ONE}; iv22 = 1;
    tick;
    iv22 = 0; a22 = '0; b22 = '0;
    chk("t1_busy_in_ready", ir22, 0);
    n = 0;
    while (!ov22 && n < 50) begin tick; n++; end
    chk("t1_latency", n, 4);
    chk("t1_c", c22, {32'h40E00000, 32'h40400000});

    // Consumer stalls for 6 cycles while a new job is offered
    iv22 = 1; a22 = {4{TWO}}; b22 = {2{TWO}};
    for (int i = 0; i < 6; i++) begin
      tick;
      chk("t2_out_valid_held", ov22, 1);
      chk("t2_in_ready_low", ir22, 0);
      chk("t2_c_stable", c22, {32'h40E00000, 32'h40400000});
    end
    iv22 = 0; or22 = 1;
    #1;
    chk("t2_in_ready_on_release", ir22, 1);
    tick;
    chk("t2_out_valid_drop", ov22, 0);
    chk("t2_c_held", c22, {32'h40E00000, 32'h40400000});
    tick;
    chk("t2_idle_no_reaccept", ov22, 0);
    chk("t2_idle_in_ready", ir22, 1);

    // Back-to-back: second job accepted on the edge that hands off the first
    a22 = {FOUR, THREE, TWO, ONE}; b22 = {ONE, ONE}; iv22 = 1;
    tick;
    a22 = {TWO, TWO, ONE, ONE}; b22 = {THREE, TWO};
    tick; tick; tick;
    chk("t3_not_yet_valid", ov22, 0);
    tick;
    chk("t3_first_valid", ov22, 1);
    chk("t3_first_c", c22, {32'h40E00000, 32'h40400000});
    chk("t3_first_in_ready", ir22, 1);
    tick;
    iv22 = 0;
    chk("t3_second_calc", ov22, 0);
    n = 0;
    while (!ov22 && n < 50) begin tick; n++; end
    chk("t3_second_latency", n, 4);
    chk("t3_second_c", c22, {32'h41200000, 32'h40A00000});
    tick;
    chk("t3_idle_after", ov22, 0);

    // Asynchronous reset two cycles into a job
    a22 = {FOUR, THREE, TWO, ONE}; b22 = {ONE, ONE}; iv22 = 1;
    tick;
    iv22 = 0;
    tick; tick;
    #2 rst = 1'b1;
    #1;
    chk("t4_async_out_valid", ov22, 0);
    chk("t4_async_c_flat", c22, 0);
    chk("t4_async_in_ready", ir22, 1);
    #1 rst = 1'b0;
    tick;
    a22 = {FOUR, THREE, TWO, ONE}; b22 = {ONE, ONE}; iv22 = 1;
    tick;
    iv22 = 0;
    n = 0;
    while (!ov22 && n < 50) begin tick; n++; end
    chk("t4_latency", n, 4);
    chk("t4_c", c22, {32'h40E00000, 32'h40400000});
    tick;

    // Overflow of the first product, round-to-nearest-even then toward zero
    a22 = {ZERO, ONE, ZERO, 32'h7F7FFFFF}; b22 = {ONE, TWO}; rm22 = 3'd0; iv22 = 1;
    tick;
    iv22 = 0;
    n = 0;
    while (!ov22 && n < 50) begin tick; n++; end
    chk("t5_rne_c", c22, {TWO, 32'h7F800000});
`ifdef MATVEC_EXC_EN
    chk("t5_rne_overflow_flag", exc22[2], 1);
    chk("t5_rne_flags", exc22, 5'b00101);
`endif
    tick;
    rm22 = 3'd1; iv22 = 1;
    tick;
    iv22 = 0;
    n = 0;
    while (!ov22 && n < 50) begin tick; n++; end
    chk("t5_rtz_c", c22, {TWO, 32'h7F7FFFFF});
    tick;
    a22 = {FOUR, THREE, TWO, ONE}; b22 = {ONE, ONE}; rm22 = 3'd0; iv22 = 1;
    tick;
    iv22 = 0;
    n = 0;
    while (!ov22 && n < 50) begin tick; n++; end
    chk("t5_clean_c", c22, {32'h40E00000, 32'h40400000});
`ifdef MATVEC_EXC_EN
    chk("t5_clean_flags", exc22, 0);
`endif

    // 3x4 instance
    a34 = {12{ONE}}; b34 = {FOUR, THREE, TWO, ONE}; iv34 = 1;
    tick;
    iv34 = 0;
    n = 0;
    while (!ov34 && n < 100) begin tick; n++; end
    chk("t6_3x4_latency", n, 12);
    chk("t6_3x4_c", c34, {3{32'h41200000}});

    // 1x1 instance: a -0.0 product must keep its sign
    a11 = 32'h80000000; b11 = ONE; iv11 = 1;
    tick;
    iv11 = 0;
    n = 0;
    while (!ov11 && n < 50) begin tick; n++; end
    chk("t7_1x1_latency", n, 1);
    chk("t7_1x1_neg_zero", c11, 32'h80000000);
`ifdef MATVEC_EXC_EN
    chk("t7_1x1_flags", exc11, 0);
`endif
    tick;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
